// File: rtl/cpu_pkg.sv
// Shared opcode, stack task and sequencer state encodings
// for the stack-machine execute block.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSH  = 4'd1;
  localparam logic [3:0] OP_DUP   = 4'd2;
  localparam logic [3:0] OP_DROP  = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_NOT   = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_SHR   = 4'd11;
  localparam logic [3:0] OP_LOADI = 4'd12;
  localparam logic [3:0] OP_PICK  = 4'd13;
  localparam logic [3:0] OP_SWAP  = 4'd14;
  localparam logic [3:0] OP_ADC   = 4'd15;

  localparam logic [1:0] TASK_STORE = 2'b00;
  localparam logic [1:0] TASK_PUSH  = 2'b01;
  localparam logic [1:0] TASK_POP   = 2'b10;
  localparam logic [1:0] TASK_SWAP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_LATCH,
    ST_GAP
  } state_t;

endpackage

// File: rtl/cpu_stack_alu.sv
// Combinational result/task selection for one stack opcode,
// with carry and zero write enables.
module cpu_stack_alu
  import cpu_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic [7:0] i_s0,
  input  logic [7:0] i_s1,
  input  logic [7:0] i_sa,
  input  logic [7:0] i_imm,
  input  logic       i_cin,
  output logic [7:0] o_r,
  output logic [1:0] o_task,
  output logic       o_cout,
  output logic       o_cwe,
  output logic       o_zout,
  output logic       o_zwe
);

  logic [8:0] w_sum;

  always_comb begin
    w_sum  = '0;
    o_r    = '0;
    o_task = TASK_STORE;
    o_cout = i_cin;
    o_cwe  = 1'b0;
    o_zwe  = 1'b0;
    unique case (i_op)
      OP_NOP:   ;
      OP_PUSH:  begin o_r = i_imm; o_task = TASK_PUSH; end
      OP_DUP:   begin o_r = i_s0;  o_task = TASK_PUSH; end
      OP_DROP:  begin o_r = i_s1;  o_task = TASK_POP;  end
      OP_ADD: begin
        w_sum  = {1'b0, i_s1} + {1'b0, i_s0};
        o_r    = w_sum[7:0];
        o_cout = w_sum[8];
        o_cwe  = 1'b1;
        o_zwe  = 1'b1;
        o_task = TASK_POP;
      end
      // 9-bit difference: bit 8 is the borrow
      OP_SUB: begin
        w_sum  = {1'b0, i_s1} - {1'b0, i_s0};
        o_r    = w_sum[7:0];
        o_cout = w_sum[8];
        o_cwe  = 1'b1;
        o_zwe  = 1'b1;
        o_task = TASK_POP;
      end
      OP_AND: begin o_r = i_s1 & i_s0; o_zwe = 1'b1; o_task = TASK_POP; end
      OP_OR:  begin o_r = i_s1 | i_s0; o_zwe = 1'b1; o_task = TASK_POP; end
      OP_XOR: begin o_r = i_s1 ^ i_s0; o_zwe = 1'b1; o_task = TASK_POP; end
      OP_NOT: begin o_r = ~i_s0; o_zwe = 1'b1; end
      OP_SHL: begin
        o_r    = {i_s0[6:0], 1'b0};
        o_cout = i_s0[7];
        o_cwe  = 1'b1;
        o_zwe  = 1'b1;
      end
      OP_SHR: begin
        o_r    = {1'b0, i_s0[7:1]};
        o_cout = i_s0[0];
        o_cwe  = 1'b1;
        o_zwe  = 1'b1;
      end
      OP_LOADI: o_r = i_imm;
      OP_PICK:  begin o_r = i_sa; o_task = TASK_PUSH; end
      OP_SWAP:  o_task = TASK_SWAP;
      OP_ADC: begin
        w_sum  = {1'b0, i_s1} + {1'b0, i_s0} + {8'd0, i_cin};
        o_r    = w_sum[7:0];
        o_cout = w_sum[8];
        o_cwe  = 1'b1;
        o_zwe  = 1'b1;
        o_task = TASK_POP;
      end
    endcase
  end

  assign o_zout = (o_r == 8'd0);

endmodule

// File: rtl/cpu_stack_exec.sv
// Execute sequencer: IDLE/EXEC/LATCH/GAP per opcode, one Latch
// pulse to the negedge stack, depth tracking and sticky flags.
module cpu_stack_exec
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          Clk,
  input  logic          nReset,
  input  logic [3:0]    Op,
  input  logic [7:0]    Imm,
  input  logic          OpValid,
  output logic          OpReady,
  output logic          Done,
  input  logic          ClearFlags,
  input  logic [7:0]    Out0,
  input  logic [7:0]    Out1,
  input  logic [7:0]    OutA,
  output logic [AW-1:0] Address,
  output logic [7:0]    StackIn,
  output logic          Latch,
  output logic [1:0]    Task,
  output logic          Carry,
  output logic          Zero,
  output logic [3:0]    Depth,
  output logic          Overflow,
  output logic          Underflow
);

  state_t     r_state, w_next;
  logic [3:0] r_op;
  logic [7:0] r_imm;
  logic [7:0] r_stackin;
  logic [1:0] r_task;
  logic       r_carry, r_zero, r_ovf, r_unf;
  logic [3:0] r_depth;

  logic [7:0] w_r;
  logic [1:0] w_task;
  logic       w_cout, w_cwe, w_zout, w_zwe;
  logic       w_push, w_pop, w_short;
  logic       w_exec, w_ovf_set, w_unf_set, w_full;
  logic [3:0] w_idx;

  cpu_stack_alu u_alu (
    .i_op   (r_op),
    .i_s0   (Out0),
    .i_s1   (Out1),
    .i_sa   (OutA),
    .i_imm  (r_imm),
    .i_cin  (r_carry),
    .o_r    (w_r),
    .o_task (w_task),
    .o_cout (w_cout),
    .o_cwe  (w_cwe),
    .o_zout (w_zout),
    .o_zwe  (w_zwe)
  );

  assign w_idx  = 4'(r_imm[AW-1:0]);
  assign w_full = (r_depth == 4'(DEPTH));
  assign w_exec = (r_state == ST_EXEC);

  // operand availability is judged against depth before the update
  always_comb begin
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_short = 1'b0;
    case (r_op)
      OP_PUSH: w_push = 1'b1;
      OP_DUP: begin
        w_push  = 1'b1;
        w_short = (r_depth == 4'd0);
      end
      OP_PICK: begin
        w_push  = 1'b1;
        w_short = (w_idx >= r_depth);
      end
      OP_DROP: begin
        w_pop   = 1'b1;
        w_short = (r_depth == 4'd0);
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADC: begin
        w_pop   = 1'b1;
        w_short = (r_depth < 4'd2);
      end
      OP_NOT, OP_SHL, OP_SHR: w_short = (r_depth == 4'd0);
      OP_SWAP: w_short = (w_idx >= r_depth);
      default: ;
    endcase
  end

  assign w_ovf_set = w_exec && w_push && w_full;
  assign w_unf_set = w_exec && w_short;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (OpValid) w_next = ST_EXEC;
      ST_EXEC:  w_next = (r_op == OP_NOP) ? ST_GAP : ST_LATCH;
      ST_LATCH: w_next = ST_GAP;
      ST_GAP:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_NOP;
      r_imm     <= '0;
      r_stackin <= '0;
      r_task    <= TASK_STORE;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_depth   <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && OpValid) begin
        r_op  <= Op;
        r_imm <= Imm;
      end
      if (w_exec) begin
        r_stackin <= w_r;
        r_task    <= w_task;
        if (w_cwe) r_carry <= w_cout;
        if (w_zwe) r_zero  <= w_zout;
        if (w_push) begin
          if (!w_full) r_depth <= r_depth + 4'd1;
        end else if (w_pop && r_depth != 4'd0) begin
          r_depth <= r_depth - 4'd1;
        end
      end
      if (w_ovf_set)       r_ovf <= 1'b1;
      else if (ClearFlags) r_ovf <= 1'b0;
      if (w_unf_set)       r_unf <= 1'b1;
      else if (ClearFlags) r_unf <= 1'b0;
    end
  end

  assign OpReady   = (r_state == ST_IDLE);
  assign Latch     = (r_state == ST_LATCH);
  assign Done      = (r_state == ST_GAP);
  assign Address   = r_imm[AW-1:0];
  assign StackIn   = r_stackin;
  assign Task      = r_task;
  assign Carry     = r_carry;
  assign Zero      = r_zero;
  assign Depth     = r_depth;
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;

endmodule

// File: tb/tb_cpu_stack_exec.sv
// Scoreboard bench for cpu_stack_exec driving a behavioural
// negedge operand stack.
module tb_cpu_stack_exec;
  import cpu_pkg::*;

  logic       Clk = 1'b0;
  logic       nReset;
  logic [3:0] Op;
  logic [7:0] Imm;
  logic       OpValid, OpReady, Done, ClearFlags;
  logic [7:0] Out0, Out1, OutA, StackIn;
  logic [2:0] Address;
  logic       Latch;
  logic [1:0] Task;
  logic       Carry, Zero, Overflow, Underflow;
  logic [3:0] Depth;

  cpu_stack_exec #(.DEPTH(8), .AW(3)) dut (
    .Clk(Clk), .nReset(nReset), .Op(Op), .Imm(Imm),
    .OpValid(OpValid), .OpReady(OpReady), .Done(Done),
    .ClearFlags(ClearFlags), .Out0(Out0), .Out1(Out1),
    .OutA(OutA), .Address(Address), .StackIn(StackIn),
    .Latch(Latch), .Task(Task), .Carry(Carry), .Zero(Zero),
    .Depth(Depth), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clk = ~Clk;

  logic [7:0] stk [8];
  assign Out0 = stk[0];
  assign Out1 = stk[1];
  assign OutA = stk[Address];

  always @(negedge Clk) begin
    if (Latch) begin
      case (Task)
        2'b00: stk[0] <= StackIn;
        2'b01: begin
          for (int i = 7; i > 0; i--) stk[i] <= stk[i-1];
          stk[0] <= StackIn;
        end
        2'b10: begin
          for (int i = 1; i < 7; i++) stk[i] <= stk[i+1];
          stk[0] <= StackIn;
        end
        default: begin
          stk[0]       <= stk[Address];
          stk[Address] <= stk[0];
        end
      endcase
    end
  end

  typedef struct {
    string nm;
    int    s0;
    bit    cs0;
    int    s1;
    bit    cs1;
    int    d;
    bit    c, z, ov, un;
    int    gap;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_done = 0;
  int   lat_cnt = 0;
  bit   prev_l = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input string nm, input int s0,
                              input bit cs0, input int d,
                              input bit c, input bit z,
                              input bit ov, input bit un,
                              input int gap);
    exp_t e;
    e.nm = nm; e.s0 = s0; e.cs0 = cs0; e.s1 = 0; e.cs1 = 0;
    e.d = d; e.c = c; e.z = z; e.ov = ov; e.un = un; e.gap = gap;
    return e;
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    cyc++;
    if (Latch) begin
      n_cmp++;
      if (prev_l) begin
        n_bad++;
        $display("FAIL latch_width: high two cycles at cyc %0d", cyc);
      end
      if (!prev_l) lat_cnt++;
    end
    prev_l = Latch;
    if (Done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got Done, want none");
      end else begin
        e = q.pop_front();
        if (e.cs0) chk({e.nm, ".s0"}, int'(stk[0]), e.s0);
        if (e.cs1) chk({e.nm, ".s1"}, int'(stk[1]), e.s1);
        chk({e.nm, ".depth"}, int'(Depth), e.d);
        chk({e.nm, ".carry"}, int'(Carry), int'(e.c));
        chk({e.nm, ".zero"}, int'(Zero), int'(e.z));
        chk({e.nm, ".ovf"}, int'(Overflow), int'(e.ov));
        chk({e.nm, ".unf"}, int'(Underflow), int'(e.un));
        if (e.gap != 0) chk({e.nm, ".gap"}, cyc - last_done, e.gap);
      end
      last_done = cyc;
    end
  end

  task automatic issue(input logic [3:0] o, input logic [7:0] im,
                       input exp_t e, input bit want, input bit clr);
    int n = 0;
    @(negedge Clk);
    while (!OpReady && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!OpReady) begin
      chk({e.nm, ".handshake"}, 0, 1);
      return;
    end
    if (want) q.push_back(e);
    Op = o;
    Imm = im;
    OpValid = 1'b1;
    @(posedge Clk);
    #1;
    OpValid = 1'b0;
    ClearFlags = clr;
    @(posedge Clk);
    #1;
    ClearFlags = 1'b0;
  endtask

  task automatic go(input logic [3:0] o, input logic [7:0] im,
                    input exp_t e);
    issue(o, im, e, 1'b1, 1'b0);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    @(negedge Clk);
    chk({nm, ".drain"}, q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    nReset = 1'b0;
    @(negedge Clk);
    nReset = 1'b1;
  endtask

  initial begin
    int   l0;
    exp_t e;
    for (int i = 0; i < 8; i++) stk[i] = 8'h00;
    nReset = 1'b0; Op = '0; Imm = '0;
    OpValid = 1'b0; ClearFlags = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst.opready", int'(OpReady), 1);
    chk("rst.latch", int'(Latch), 0);
    chk("rst.done", int'(Done), 0);
    chk("rst.depth", int'(Depth), 0);
    chk("rst.flags", int'({Carry, Zero, Overflow, Underflow}), 0);
    chk("rst.bus", int'({Address, StackIn, Task}), 0);
    nReset = 1'b1;

    l0 = lat_cnt;
    go(OP_PUSH, 8'h05, mk("push05", 'h05, 1, 1, 0, 0, 0, 0, 0));
    go(OP_PUSH, 8'h03, mk("push03", 'h03, 1, 2, 0, 0, 0, 0, 4));
    go(OP_ADD,  8'h00, mk("add8",   'h08, 1, 1, 0, 0, 0, 0, 4));
    drain("seq1");
    chk("seq1.latches", lat_cnt - l0, 3);

    go(OP_PUSH, 8'hFF, mk("pushff", 'hFF, 1, 2, 0, 0, 0, 0, 0));
    go(OP_PUSH, 8'h01, mk("push01", 'h01, 1, 3, 0, 0, 0, 0, 0));
    go(OP_ADD,  8'h00, mk("addcy",  'h00, 1, 2, 1, 1, 0, 0, 0));
    go(OP_PUSH, 8'h00, mk("push00", 'h00, 1, 3, 1, 1, 0, 0, 0));
    go(OP_ADC,  8'h00, mk("adc",    'h01, 1, 2, 0, 0, 0, 0, 0));
    go(OP_PUSH, 8'h02, mk("push02", 'h02, 1, 3, 0, 0, 0, 0, 0));
    go(OP_PUSH, 8'h03, mk("push03b",'h03, 1, 4, 0, 0, 0, 0, 0));
    go(OP_SUB,  8'h00, mk("sub",    'hFF, 1, 3, 1, 0, 0, 0, 0));
    drain("seq2");

    do_reset();
    for (int i = 0; i < 8; i++)
      go(OP_PUSH, 8'(8'h10 + i),
         mk("fill", 8'h10 + i, 1, i + 1, 0, 0, 0, 0, 0));
    e = mk("push9", 'h18, 1, 8, 0, 0, 1, 0, 0);
    issue(OP_PUSH, 8'h18, e, 1'b1, 1'b1);
    drain("seq4");
    @(negedge Clk);
    ClearFlags = 1'b1;
    @(negedge Clk);
    ClearFlags = 1'b0;
    chk("clr.ovf", int'(Overflow), 0);
    chk("clr.depth", int'(Depth), 8);

    do_reset();
    l0 = lat_cnt;
    go(OP_ADD, 8'h00, mk("add_empty", 0, 0, 0, 0, 0, 0, 1, 0));
    drain("seq5");
    chk("seq5.latches", lat_cnt - l0, 1);

    do_reset();
    go(OP_PUSH, 8'h11, mk("p11", 'h11, 1, 1, 0, 0, 0, 0, 0));
    go(OP_PUSH, 8'h22, mk("p22", 'h22, 1, 2, 0, 0, 0, 0, 0));
    go(OP_PUSH, 8'h33, mk("p33", 'h33, 1, 3, 0, 0, 0, 0, 0));
    go(OP_PICK, 8'h02, mk("pick2", 'h11, 1, 4, 0, 0, 0, 0, 0));
    go(OP_SWAP, 8'h03, mk("swap3", 'h11, 1, 4, 0, 0, 0, 0, 0));
    e = mk("swap1", 'h33, 1, 4, 0, 0, 0, 0, 0);
    e.s1 = 'h11;
    e.cs1 = 1'b1;
    go(OP_SWAP, 8'h01, e);
    go(OP_SWAP, 8'h04, mk("swap4", 0, 0, 4, 0, 0, 0, 1, 0));
    drain("seq6");

    issue(OP_PUSH, 8'h55, e, 1'b0, 1'b0);
    chk("mid.latch_hi", int'(Latch), 1);
    nReset = 1'b0;
    #1;
    chk("mid.latch", int'(Latch), 0);
    chk("mid.opready", int'(OpReady), 1);
    chk("mid.depth", int'(Depth), 0);
    @(negedge Clk);
    nReset = 1'b1;
    go(OP_PUSH, 8'h42, mk("p42", 'h42, 1, 1, 0, 0, 0, 0, 0));
    go(OP_PUSH, 8'h0F, mk("p0f", 'h0F, 1, 2, 0, 0, 0, 0, 0));
    go(OP_AND,  8'h00, mk("and", 'h02, 1, 1, 0, 0, 0, 0, 0));
    go(OP_PUSH, 8'hF0, mk("pf0", 'hF0, 1, 2, 0, 0, 0, 0, 0));
    go(OP_OR,   8'h00, mk("or",  'hF2, 1, 1, 0, 0, 0, 0, 0));
    go(OP_DUP,  8'h00, mk("dup", 'hF2, 1, 2, 0, 0, 0, 0, 0));
    go(OP_XOR,  8'h00, mk("xor", 'h00, 1, 1, 0, 1, 0, 0, 0));
    go(OP_NOT,  8'h00, mk("not", 'hFF, 1, 1, 0, 0, 0, 0, 0));
    go(OP_SHL,  8'h00, mk("shl", 'hFE, 1, 1, 1, 0, 0, 0, 0));
    go(OP_SHR,  8'h00, mk("shr", 'h7F, 1, 1, 0, 0, 0, 0, 0));
    go(OP_LOADI,8'h80, mk("ldi", 'h80, 1, 1, 0, 0, 0, 0, 0));
    go(OP_SHL,  8'h00, mk("shl0",'h00, 1, 1, 1, 1, 0, 0, 0));
    drain("seq8a");
    l0 = lat_cnt;
    go(OP_NOP,  8'h00, mk("nop", 'h00, 1, 1, 1, 1, 0, 0, 0));
    drain("nop");
    chk("nop.latches", lat_cnt - l0, 0);
    go(OP_DROP, 8'h00, mk("drop1", 0, 0, 0, 1, 1, 0, 0, 0));
    go(OP_DROP, 8'h00, mk("drop0", 0, 0, 0, 1, 1, 0, 1, 0));
    drain("seq8b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_stack_exec.md
Name: cpu_stack_exec

Overview:
- Execute sequencer and ALU that drives the 8-deep, 8-bit CPU operand stack, which is negedge-clocked and triggers on the rising edge of Latch.
- Accepts one stack-machine opcode at a time over a valid/ready handshake.
- Reads s0, s1 and sA, computes the result, then issues exactly one Latch pulse with the matching Task, Input and Address.
- Also tracks stack depth, with Carry/Zero and sticky Overflow/Underflow flags.

Parameters:
- DEPTH, 8, stack entries; must equal the stack instance depth.
- AW, 3, stack address width (log2 DEPTH).

Ports:
- Clk, input, 1, clock; all state updates on the rising edge.
- nReset, input, 1, reset: asynchronous, active-low.
- Op, input, 4, opcode; sampled on handshake.
- Imm, input, 8, immediate or stack index; sampled on handshake.
- OpValid, input, 1, opcode valid.
- OpReady, output, 1, high in IDLE only.
- Done, output, 1, one-cycle pulse when the op's stack update is visible.
- ClearFlags, input, 1, clears Overflow/Underflow; ignored during reset.
- Out0, input, 8, stack s0.
- Out1, input, 8, stack s1.
- OutA, input, 8, stack s[Address].
- Address, output, AW, stack index.
- StackIn, output, 8, to stack Input.
- Latch, output, 1, to stack Latch.
- Task, output, 2, to stack Task: 00 store s0, 01 push, 10 store s0 + pop, 11 swap s0/sA.
- Carry, output, 1, ALU carry/borrow.
- Zero, output, 1, last ALU result == 0.
- Depth, output, 4, entries in use (0..8).
- Overflow, output, 1, sticky.
- Underflow, output, 1, sticky.

Behaviour:
- Reset (asynchronous, any state, including mid-op): state IDLE. All outputs 0 except OpReady=1.
- States and transitions:
  - IDLE→EXEC on OpValid&OpReady (edge T0). Op and Imm are registered; Address=Imm[AW-1:0] from T0.
  - EXEC→LATCH at T1: StackIn, Task and flags are registered from Out0/Out1/OutA.
  - LATCH: Latch=1 for exactly one cycle (T1..T2). The stack updates at the mid-cycle negedge.
  - GAP (T2..T3): Latch=0, Done=1.
  - GAP→IDLE at T3.
- Throughput: one op per 4 cycles. Latch is never high in two consecutive cycles; at least one low cycle separates pulses.
- NOP (0): EXEC→GAP directly. No Latch; Done still pulses.
- Opcodes (result R, Task):
  - 1 PUSH: R=Imm, Task 01.
  - 2 DUP: R=s0, Task 01.
  - 3 DROP: R=s1, Task 10.
  - 4 ADD: R=s1+s0, Task 10.
  - 5 SUB: R=s1-s0, Task 10.
  - 6 AND / 7 OR / 8 XOR: R=s1 op s0, Task 10.
  - 9 NOT: R=~s0, Task 00.
  - 10 SHL: R=s0<<1, Task 00.
  - 11 SHR: R=s0>>1 (logical), Task 00.
  - 12 LOADI: R=Imm, Task 00.
  - 13 PICK: R=sA, Task 01.
  - 14 SWAP: Task 11, StackIn don't-care (driven 0).
  - 15 ADC: R=s1+s0+Carry, Task 10.
- Arithmetic: 9-bit internal sum; R is bits [7:0].
  - ADD/ADC: Carry is bit 8.
  - SUB: Carry=1 on borrow (s0>s1).
  - SHL: Carry=s0[7]. SHR: Carry=s0[0].
  - Other ops leave Carry unchanged.
  - Zero=(R==0) for ops 4-11 and 15; other ops leave Zero unchanged.
- Depth, updated at T1:
  - Push ops (1, 2, 13): Depth+1. If already DEPTH, Depth stays DEPTH and Overflow=1.
  - Pop ops (3-8, 15): Depth-1, floored at 0.
- Underflow is set at T1 when the required operands exceed Depth:
  - Binary ops: Depth<2.
  - DROP, NOT, SHL, SHR, DUP: Depth<1.
  - PICK, SWAP: Imm[AW-1:0]>=Depth.
- Faulting ops still execute; the stack contents are whatever the hardware yields.
- ClearFlags in the same cycle as a flag set: the set wins.
- OpValid while busy is ignored. Op/Imm need not be held after the handshake.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_NOP..OP_ADC (4-bit);
  - Task encodings TASK_STORE=00, TASK_PUSH=01, TASK_POP=10, TASK_SWAP=11;
  - state encoding.
- One natural combinational sub-module: cpu_stack_alu (Op, s0, s1, sA, Imm, CarryIn → R, Task, CarryOut, ZeroOut, carry/zero write enables).
- The sequencer, depth counter and flags stay in cpu_stack_exec.

Test Plan:
- Reset, then PUSH 0x05, PUSH 0x03, ADD → Latch pulses 3 times, each 1 cycle with a low gap. Final s0=0x08, Depth=1, Carry=0, Zero=0; Done pulses 3 times, 4 cycles apart.
- PUSH 0xFF, PUSH 0x01, ADD, then PUSH 0x00, ADC → first s0=0x00 with Carry=1, Zero=1; then s0=0x01 with Carry=0.
- PUSH 0x02, PUSH 0x03, SUB → s0=0xFF, Carry=1 (borrow).
- PUSH 9 values → the 9th push sets Overflow=1 with Depth=8. ClearFlags → Overflow=0.
- From reset, ADD → Underflow=1, Depth=0, one Latch pulse issued.
- PUSH 0x11, 0x22, 0x33, then PICK 2 → s0=0x11, Depth=4. SWAP 3 → s0=0x11 and s3=0x11 (no change since equal). Repeat with SWAP 1 → s0=0x33, s1=0x11.
- Assert nReset during LATCH → Latch=0 immediately, OpReady=1, Depth=0, next op accepted normally.
